// File: rtl/canny_hysteresis.sv
// Hysteresis stage of the Canny edge detector: double-threshold classification
// plus single-pass weak-to-strong promotion over a 3x3 window fed by two line buffers.
module canny_hysteresis #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 720,
  parameter int BIT_LENGTH = 5,
  parameter int LOW_TH     = 8,
  parameter int HIGH_TH    = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  output logic                  out_valid,
  output logic                  edge_out,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [BIT_LENGTH-1:0] LOW_V    = BIT_LENGTH'(LOW_TH);
  localparam logic [BIT_LENGTH-1:0] HIGH_V   = BIT_LENGTH'(HIGH_TH);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_WEAK   = 2'b01,
    CLS_STRONG = 2'b10
  } cls_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, ocol;
  logic [RW-1:0]   row, orow;
  cls_t            win     [3][3];
  cls_t            win_nxt [3][3];
  cls_t            lb0     [IMG_WIDTH];
  cls_t            lb1     [IMG_WIDTH];
  cls_t            cls_in, lb0_rd, lb1_rd;
  logic            accept, emit, in_last, out_last, out_border, strong_nb, edge_calc;
  logic            out_valid_d, edge_out_d, frame_done_d;

  assign accept   = in_valid && (state == S_IDLE || state == S_FILL || state == S_RUN);
  assign emit     = accept && (state == S_RUN ||
                    (state == S_FILL && row == RW'(1) && col == CW'(1)));
  assign in_last  = (col == COL_LAST) && (row == ROW_LAST);
  assign out_last = (ocol == COL_LAST) && (orow == ROW_LAST);
  assign lb0_rd   = lb0[col];
  assign lb1_rd   = lb1[col];

  always_comb begin
    if (pixel_in >= HIGH_V)     cls_in = CLS_STRONG;
    else if (pixel_in >= LOW_V) cls_in = CLS_WEAK;
    else                        cls_in = CLS_NONE;
  end

  // Window after this acceptance: rows are (two rows up, one row up, current).
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) win_nxt[r][c] = win[r][c+1];
    end
    win_nxt[0][2] = lb1_rd;
    win_nxt[1][2] = lb0_rd;
    win_nxt[2][2] = cls_in;
  end

  // NOTE: every always_comb output gets a default before any conditional write,
  // otherwise the missing path infers a latch.
  always_comb begin
    strong_nb = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1) && win_nxt[r][c] == CLS_STRONG) strong_nb = 1'b1;
      end
    end
  end

  assign out_border = (orow == '0) || (orow == ROW_LAST) || (ocol == '0) || (ocol == COL_LAST);

  always_comb begin
    edge_calc = 1'b0;
    if (!out_border) begin
      case (win_nxt[1][1])
        CLS_STRONG: edge_calc = 1'b1;
        CLS_WEAK:   edge_calc = strong_nb;
        default:    edge_calc = 1'b0;
      endcase
    end
  end

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FILL;
      S_FILL:  if (emit) state_nxt = S_RUN;
      S_RUN:   if (accept && in_last) state_nxt = S_FLUSH;
      S_FLUSH: if (out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic; flush outputs are all border pixels
  always_comb begin
    out_valid_d  = emit || (state == S_FLUSH);
    edge_out_d   = emit && edge_calc;
    frame_done_d = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      ocol       <= '0;
      orow       <= '0;
      win        <= '{default: CLS_NONE};
      out_valid  <= 1'b0;
      edge_out   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= out_valid_d;
      edge_out   <= edge_out_d;
      frame_done <= frame_done_d;
      if (accept) begin
        win <= win_nxt;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (out_valid_d) begin
        if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= (orow == ROW_LAST) ? '0 : orow + RW'(1);
        end else begin
          ocol <= ocol + CW'(1);
        end
      end
      if (state == S_DONE) begin
        col  <= '0;
        row  <= '0;
        ocol <= '0;
        orow <= '0;
      end
    end
  end

  // NOTE: line buffers have no reset; stale entries only ever reach border outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= cls_in;
    end
  end

endmodule

// File: tb/tb_canny_hysteresis.sv
// Scoreboard bench for canny_hysteresis on an 8x6 frame: directed frames with
// hand-computed edge maps, gapped input, and a mid-frame reset.
module tb_canny_hysteresis;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int BL = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [BL-1:0] pixel_in;
  logic          out_valid;
  logic          edge_out;
  logic          frame_done;

  canny_hysteresis #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_LENGTH(BL), .LOW_TH(8), .HIGH_TH(20)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pixel_in(pixel_in),
    .out_valid(out_valid), .edge_out(edge_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  logic exp_q[$];
  int   pix[N];
  logic expv[N];
  int   acc_cnt = 0;
  logic last_acc = 1'b0;
  logic check_en = 1'b0;
  int   out_cnt = 0;
  int   done_cnt = 0;
  logic prev_ov = 1'b0;
  logic prev_fd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!reset) begin
      out_cnt = 0;
      prev_ov = 1'b0;
      prev_fd = 1'b0;
    end else begin
      if (out_valid) begin
        if (check_en) begin
          if (out_cnt <= N - W - 2) begin
            check($sformatf("latency[%0d]", out_cnt), acc_cnt, out_cnt + W + 2);
            check($sformatf("after_accept[%0d]", out_cnt), last_acc, 1);
          end
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output[%0d]: got out_valid=1, expected none", out_cnt);
          end else begin
            logic e;
            e = exp_q.pop_front();
            check($sformatf("edge[%0d]", out_cnt), edge_out, e);
          end
        end
        out_cnt++;
      end
      if (frame_done) begin
        if (check_en) begin
          check("frame_len", out_cnt, N);
          check("done_after_last_out", prev_ov, 1);
          check("done_single_pulse", prev_fd, 0);
        end
        out_cnt = 0;
        done_cnt++;
      end
      prev_ov = out_valid;
      prev_fd = frame_done;
    end
  end

  task automatic drive(input logic v, input int p);
    in_valid = v;
    pixel_in = BL'(p);
    @(posedge clk);
    #1;
    if (v) acc_cnt++;
    last_acc = v;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      pix[i]  = 0;
      expv[i] = 1'b0;
    end
  endtask

  task automatic set_px(input int r, input int c, input int v);
    pix[r*W + c] = v;
  endtask

  task automatic setup_s2();
    clear_frame();
    set_px(2, 3, 25);
    set_px(2, 4, 10);
    set_px(4, 6, 10);
    expv[19] = 1'b1;
    expv[20] = 1'b1;
  endtask

  task automatic wait_done();
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < 400) begin
      drive(1'b0, 0);
      k++;
    end
    if (done_cnt == start) begin
      n_vec++;
      n_miss++;
      $display("FAIL frame_done_timeout: got no pulse, expected one within 400 cycles");
      exp_q.delete();
    end
    repeat (3) drive(1'b0, 0);
  endtask

  task automatic run_frame(input logic toggle);
    acc_cnt = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(expv[i]);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, pix[i]);
      if (toggle) drive(1'b0, 0);
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    pixel_in = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_edge_out", edge_out, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_en = 1'b1;
    repeat (2) drive(1'b0, 0);

    // 1: all-zero frame
    clear_frame();
    run_frame(1'b0);

    // 2: strong + adjacent weak + isolated weak
    setup_s2();
    run_frame(1'b0);

    // 3: exact threshold values
    clear_frame();
    set_px(2, 2, 20);
    set_px(2, 3, 8);
    set_px(3, 3, 7);
    expv[18] = 1'b1;
    expv[19] = 1'b1;
    run_frame(1'b0);

    // 4: strong border row 0 and column 0
    clear_frame();
    for (int c = 0; c < W; c++) set_px(0, c, 31);
    for (int r = 0; r < H; r++) set_px(r, 0, 31);
    run_frame(1'b0);

    // 5: scenario 2 with gapped input
    setup_s2();
    run_frame(1'b1);

    // 6: abort a frame with reset after 20 pixels, then a clean scenario 2 frame
    check_en = 1'b0;
    setup_s2();
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) drive(1'b1, pix[i]);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_edge_out", edge_out, 0);
    check("midrst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_en = 1'b1;
    repeat (4) begin
      drive(1'b0, 0);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_frame_done", frame_done, 0);
    end
    run_frame(1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/canny_hysteresis.md
# canny_hysteresis

Final stage of the edge-detection pipeline. It sits directly downstream of the non-maximum-suppression stage and consumes its thinned gradient stream, one `BIT_LENGTH` pixel per cycle, in raster order. Each pixel is classified by a double threshold (strong, weak or none). A weak pixel is promoted to an edge when any of its 8 neighbours is strong. The block emits a 1-bit edge map in raster order and uses two internal line buffers.

## Interface
- `IMG_WIDTH`, 960, pixels per row (≥4)
- `IMG_HEIGHT`, 720, rows per frame (≥3)
- `BIT_LENGTH`, 5, input pixel width
- `LOW_TH`, 8, weak threshold (unsigned, `BIT_LENGTH` bits)
- `HIGH_TH`, 20, strong threshold (unsigned, `HIGH_TH` > `LOW_TH`)
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  reset; one clock; reset is asynchronous and active-low
- `in_valid`  in  1  pixel_in valid this cycle (driven by upstream `readable`)
- `pixel_in`  in  BIT_LENGTH  suppressed gradient magnitude
- `out_valid`  out  1  edge_out valid this cycle
- `edge_out`  out  1  1 = edge pixel
- `frame_done`  out  1  one-cycle pulse after the last output of a frame

## Operation
- Classification, using unsigned compares:
  - `pixel_in >= HIGH_TH` gives STRONG (2'b10).
  - `pixel_in >= LOW_TH` gives WEAK (2'b01).
  - Anything else gives NONE (2'b00).
- Only 2-bit classes are stored. Storage is two line buffers of `IMG_WIDTH` x 2 bits plus a 3x3 window of class registers.
- A pixel is accepted when `in_valid`=1 in IDLE, FILL or RUN.
  - Acceptance shifts the window by one and writes the line buffers at the input column.
  - When `in_valid`=0, the window, the buffers and the counters hold, with no output. Gaps of any length are legal.
- Input counters: `col` runs 0..W-1 and wraps to 0 with `row`+1. `row` runs 0..H-1.
- Output index k is produced when input index k+W+1 is accepted, so the centre of the window is pixel k.
- Output rule for centre pixel (r,c):
  - If r=0, r=H-1, c=0 or c=W-1 (border), `edge_out`=0.
  - Otherwise STRONG gives 1.
  - WEAK gives 1 if any of the 8 neighbour classes is STRONG, else 0.
  - NONE gives 0.
- Promotion is single-pass. Neighbour classes are the original classes; promoted pixels never propagate.
- Window contents that wrap across a row boundary only ever affect border columns, and those are forced to 0.
- FSM:
  - IDLE: no pixel of the frame accepted yet. On acceptance, go to FILL.
  - FILL: inputs 0..W accepted, no output. Accepting input index W+1 emits output 0 and moves to RUN.
  - RUN: each acceptance emits one output. Accepting input W·H−1, the last pixel, emits output W·H−W−2 and moves to FLUSH.
  - FLUSH: emits the remaining W+1 outputs, one per cycle, with no input required. All of them are border pixels, so `edge_out`=0. After the last one, go to DONE.
  - DONE: `frame_done`=1 for exactly one cycle, then IDLE. Counters are cleared for the next frame.
- `in_valid` during FLUSH or DONE is ignored; no pixel is accepted. Upstream must not send the next frame before `frame_done`.
- Every frame yields exactly W·H outputs.

## Timing
- Reset (`reset`=0, asynchronous):
  - Outputs: `out_valid`=0, `edge_out`=0, `frame_done`=0.
  - State is IDLE, the counters are 0 and the window is cleared to NONE.
  - Line-buffer contents need not be cleared.
  - Reset asserted mid-frame aborts the frame immediately. The next accepted pixel is treated as pixel (0,0).
- All outputs are registered.
  - `out_valid`/`edge_out` are asserted in the cycle after the accepting clock edge.
  - Latency from input (r,c) to output (r,c) is W+1 accepted pixels plus 1 cycle.
- FLUSH outputs occur on W+1 consecutive cycles.
- `frame_done` rises the cycle after the last FLUSH output.
- Throughput is 1 pixel per cycle sustained. `out_valid` never asserts without a prior acceptance, except in FLUSH.

## Test plan
Bench parameters for all scenarios: W=8, H=6, LOW_TH=8, HIGH_TH=20.
1. All-zero frame, `in_valid` held high → 48 outputs, all `edge_out`=0. The first `out_valid` comes 1 cycle after the 10th acceptance. `frame_done` pulses once, 1 cycle after output 47.
2. Pixel (2,3)=25 (strong), (2,4)=10 (weak), (4,6)=10 (isolated weak), rest 0 → edges exactly at indices 19 and 20. Index 38 (4,6) is 0.
3. Thresholds exactly: (2,2)=20 and (2,3)=8, (3,3)=7 → (2,2)=1 and (2,3)=1. (3,3)=0, because NONE is not promoted.
4. Border: strong value 31 in all of row 0 and column 0 → every border output is 0. Interior pixels (1,1) and (1,2) are 0 because their class is NONE.
5. Same stimulus as scenario 2 with `in_valid` toggling 1/0 every cycle → identical output sequence. `out_valid` is asserted only after acceptances and during FLUSH.
6. Drive `reset`=0 after 20 pixels, release it, then send the full scenario 2 frame → outputs match scenario 2, with no leftover `out_valid` and no stale `frame_done`.
